// File: rtl/spectrum_peak_finder_if.sv
// Bin stream in, per-frame peak report out, for spectrum_peak_finder.
// SPECTRUM_PEAK_MEAN_EN adds the mean_o result signal.
interface spectrum_peak_finder_if #(
  parameter int DW   = 18,
  parameter int BINS = 512
);
  localparam int IW = $clog2(BINS);

  logic [DW-1:0] mag_i;
  logic          sob_i;
  logic          eob_i;
  logic [IW-1:0] peak_idx_o;
  logic [DW-1:0] peak_mag_o;
`ifdef SPECTRUM_PEAK_MEAN_EN
  logic [DW-1:0] mean_o;
`endif
  logic          frame_err_o;
  logic          valid_o;

`ifdef SPECTRUM_PEAK_MEAN_EN
  modport master (output mag_i, sob_i, eob_i,
                  input  peak_idx_o, peak_mag_o, mean_o, frame_err_o, valid_o);
  modport slave  (input  mag_i, sob_i, eob_i,
                  output peak_idx_o, peak_mag_o, mean_o, frame_err_o, valid_o);
`else
  modport master (output mag_i, sob_i, eob_i,
                  input  peak_idx_o, peak_mag_o, frame_err_o, valid_o);
  modport slave  (input  mag_i, sob_i, eob_i,
                  output peak_idx_o, peak_mag_o, frame_err_o, valid_o);
`endif
endinterface

// File: rtl/spectrum_peak_finder.sv
// Per-frame peak (index, magnitude) finder with frame-length check.
// Define SPECTRUM_PEAK_MEAN_EN to add the frame mean (acc >> IW) on mean_o.
module spectrum_peak_finder #(
  parameter int DW   = 18,
  parameter int BINS = 512
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  spectrum_peak_finder_if.slave  bus
);
  localparam int           IW     = $clog2(BINS);
  localparam logic [IW:0]  BINS_C = (IW+1)'(BINS);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [IW:0]   cnt_q, cnt_d;
  logic          over_q, over_d;
  logic [DW-1:0] max_mag_q, max_mag_d;
  logic [IW-1:0] max_idx_q, max_idx_d;
  logic [IW-1:0] peak_idx_q, peak_idx_d;
  logic [DW-1:0] peak_mag_q, peak_mag_d;
  logic          err_q, err_d;
  logic          valid_q, valid_d;
`ifdef SPECTRUM_PEAK_MEAN_EN
  logic [DW+IW-1:0] acc_q, acc_d;
  logic [DW-1:0]    mean_q, mean_d;
`endif

  logic in_run, counted, report;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    over_d     = over_q;
    max_mag_d  = max_mag_q;
    max_idx_d  = max_idx_q;
    peak_idx_d = peak_idx_q;
    peak_mag_d = peak_mag_q;
    err_d      = err_q;
    valid_d    = 1'b0;
`ifdef SPECTRUM_PEAK_MEAN_EN
    acc_d      = acc_q;
    mean_d     = mean_q;
`endif
    in_run  = (state_q == RUN);
    // Index BINS and above are past the expected frame: count as overflow only.
    counted = in_run && !over_q && (cnt_q < BINS_C);
    report  = bus.eob_i && (bus.sob_i || in_run);

    if (bus.sob_i) begin
      // Any frame in progress is dropped; this bin is bin 0 of a new one.
      state_d   = bus.eob_i ? IDLE : RUN;
      cnt_d     = (IW+1)'(1);
      over_d    = 1'b0;
      max_mag_d = bus.mag_i;
      max_idx_d = '0;
`ifdef SPECTRUM_PEAK_MEAN_EN
      acc_d     = {{IW{1'b0}}, bus.mag_i};
`endif
    end else if (in_run) begin
      if (counted) begin
        cnt_d = cnt_q + (IW+1)'(1);
        if (bus.mag_i > max_mag_q) begin
          max_mag_d = bus.mag_i;
          max_idx_d = cnt_q[IW-1:0];
        end
`ifdef SPECTRUM_PEAK_MEAN_EN
        acc_d = acc_q + {{IW{1'b0}}, bus.mag_i};
`endif
      end else begin
        over_d = 1'b1;
      end
      if (bus.eob_i) state_d = IDLE;
    end

    // Results include the eob bin, so they are taken from the next-state values.
    if (report) begin
      valid_d    = 1'b1;
      peak_idx_d = max_idx_d;
      peak_mag_d = max_mag_d;
      err_d      = over_d | (cnt_d != BINS_C);
`ifdef SPECTRUM_PEAK_MEAN_EN
      mean_d     = acc_d[DW+IW-1:IW];
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      over_q     <= 1'b0;
      max_mag_q  <= '0;
      max_idx_q  <= '0;
      peak_idx_q <= '0;
      peak_mag_q <= '0;
      err_q      <= 1'b0;
      valid_q    <= 1'b0;
`ifdef SPECTRUM_PEAK_MEAN_EN
      acc_q      <= '0;
      mean_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      over_q     <= over_d;
      max_mag_q  <= max_mag_d;
      max_idx_q  <= max_idx_d;
      peak_idx_q <= peak_idx_d;
      peak_mag_q <= peak_mag_d;
      err_q      <= err_d;
      valid_q    <= valid_d;
`ifdef SPECTRUM_PEAK_MEAN_EN
      acc_q      <= acc_d;
      mean_q     <= mean_d;
`endif
    end
  end

  assign bus.peak_idx_o  = peak_idx_q;
  assign bus.peak_mag_o  = peak_mag_q;
  assign bus.frame_err_o = err_q;
  assign bus.valid_o     = valid_q;
`ifdef SPECTRUM_PEAK_MEAN_EN
  assign bus.mean_o      = mean_q;
`endif

endmodule

// File: tb/tb_spectrum_peak_finder.sv
// Randomized bench for spectrum_peak_finder against a frame-level reference model.
module tb_spectrum_peak_finder;
  localparam int DW   = 18;
  localparam int BINS = 512;
  localparam int IW   = $clog2(BINS);

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [DW-1:0] peak;
    logic [DW-1:0] mean;
    logic          err;
    int            cyc;
  } res_t;

  logic clk;
  logic rst_n;
  int   vectors = 0;
  int   errors  = 0;
  int   cyc     = 0;

  res_t          obs_q[$];
  res_t          exp_q[$];
  logic [DW-1:0] cur[$];
  bit            in_frame = 0;

  spectrum_peak_finder_if #(.DW(DW), .BINS(BINS)) bus ();

  spectrum_peak_finder #(.DW(DW), .BINS(BINS)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame-level reference: first BINS bins only, strict max, sum / BINS.
  function automatic res_t model(input logic [DW-1:0] b[$], input int c);
    res_t    r;
    longint  sum;
    int      n;
    int      lim;
    n   = b.size();
    lim = (n < BINS) ? n : BINS;
    sum = 0;
    r   = '0;
    r.peak = b[0];
    for (int i = 0; i < lim; i++) begin
      if (b[i] > r.peak) begin
        r.peak = b[i];
        r.idx  = IW'(i);
      end
      sum += longint'(b[i]);
    end
`ifdef SPECTRUM_PEAK_MEAN_EN
    r.mean = DW'(sum / BINS);
`endif
    r.err = (n != BINS);
    r.cyc = c;
    return r;
  endfunction

  // One clock: sample results, drive the next bin, update the model.
  task automatic step(input logic [DW-1:0] m, input logic s, input logic e);
    res_t o;
    @(negedge clk);
    cyc++;
    if (bus.valid_o === 1'b1) begin
      o = '0;
      o.idx  = bus.peak_idx_o;
      o.peak = bus.peak_mag_o;
      o.err  = bus.frame_err_o;
`ifdef SPECTRUM_PEAK_MEAN_EN
      o.mean = bus.mean_o;
`endif
      o.cyc  = cyc;
      obs_q.push_back(o);
    end
    bus.mag_i = m;
    bus.sob_i = s;
    bus.eob_i = e;
    if (s) begin
      cur.delete();
      in_frame = 1;
    end
    if (in_frame) begin
      cur.push_back(m);
      if (e) begin
        exp_q.push_back(model(cur, cyc + 1));
        in_frame = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step('0, 1'b0, 1'b0);
  endtask

  task automatic send_frame(input logic [DW-1:0] b[$]);
    foreach (b[i]) step(b[i], i == 0, i == b.size() - 1);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.mag_i = '0; bus.sob_i = 1'b0; bus.eob_i = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", bus.valid_o); end
    vectors++; if (bus.peak_idx_o !== '0) begin errors++; $display("FAIL reset_idx: got %0d, expected 0", bus.peak_idx_o); end
    vectors++; if (bus.peak_mag_o !== '0) begin errors++; $display("FAIL reset_peak: got %0d, expected 0", bus.peak_mag_o); end
    vectors++; if (bus.frame_err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b, expected 0", bus.frame_err_o); end
`ifdef SPECTRUM_PEAK_MEAN_EN
    vectors++; if (bus.mean_o !== '0) begin errors++; $display("FAIL reset_mean: got %0d, expected 0", bus.mean_o); end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_nominal;
    logic [DW-1:0] b[$];
    res_t e;
    for (int k = 0; k < BINS; k++) b.push_back(DW'(k));
    send_frame(b);
    idle(6);
    vectors++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL nominal_count: got %0d results, expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL nominal[%0d]: idx=%0d peak=%0d mean=%0d err=%b cyc=%0d, expected idx=%0d peak=%0d mean=%0d err=%b cyc=%0d", i, obs_q[i].idx, obs_q[i].peak, obs_q[i].mean, obs_q[i].err, obs_q[i].cyc, exp_q[i].idx, exp_q[i].peak, exp_q[i].mean, exp_q[i].err, exp_q[i].cyc); end
    end
    // Results must hold well after the valid pulse.
    if (exp_q.size() > 0) begin
      e = exp_q[0];
      vectors++; if (bus.peak_idx_o !== e.idx || bus.peak_mag_o !== e.peak) begin errors++; $display("FAIL nominal_hold: idx=%0d peak=%0d, expected idx=%0d peak=%0d", bus.peak_idx_o, bus.peak_mag_o, e.idx, e.peak); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_tie_back_to_back;
    logic [DW-1:0] b1[$];
    logic [DW-1:0] b2[$];
    for (int k = 0; k < BINS; k++) begin
      b1.push_back((k == 7 || k == 300) ? DW'(1000) : '0);
      b2.push_back((k == 0) ? DW'(5) : '0);
    end
    send_frame(b1);
    send_frame(b2);
    idle(3);
    vectors++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL tie_b2b_count: got %0d results, expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL tie_b2b[%0d]: idx=%0d peak=%0d mean=%0d err=%b cyc=%0d, expected idx=%0d peak=%0d mean=%0d err=%b cyc=%0d", i, obs_q[i].idx, obs_q[i].peak, obs_q[i].mean, obs_q[i].err, obs_q[i].cyc, exp_q[i].idx, exp_q[i].peak, exp_q[i].mean, exp_q[i].err, exp_q[i].cyc); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_short_long;
    logic [DW-1:0] b[$];
    for (int k = 0; k < 100; k++) b.push_back((k == 50) ? DW'(70000) : DW'($urandom_range(0, 60000)));
    send_frame(b);
    idle(2);
    b.delete();
    for (int k = 0; k < 600; k++) b.push_back((k == 550) ? DW'(200000) : DW'($urandom_range(0, 150000)));
    send_frame(b);
    b.delete();
    for (int k = 0; k < BINS + 1; k++) b.push_back(DW'($urandom_range(0, 1000)));
    send_frame(b);
    idle(3);
    vectors++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL short_long_count: got %0d results, expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL short_long[%0d]: idx=%0d peak=%0d mean=%0d err=%b cyc=%0d, expected idx=%0d peak=%0d mean=%0d err=%b cyc=%0d", i, obs_q[i].idx, obs_q[i].peak, obs_q[i].mean, obs_q[i].err, obs_q[i].cyc, exp_q[i].idx, exp_q[i].peak, exp_q[i].mean, exp_q[i].err, exp_q[i].cyc); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_restart_orphan;
    logic [DW-1:0] b[$];
    for (int k = 0; k < 200; k++) step(DW'($urandom_range(100000, 200000)), k == 0, 1'b0);
    for (int k = 0; k < BINS; k++) b.push_back(DW'($urandom_range(0, 50000)));
    send_frame(b);
    idle(3);
    step(DW'(123), 1'b0, 1'b1);
    idle(3);
    vectors++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL restart_count: got %0d results, expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL restart[%0d]: idx=%0d peak=%0d mean=%0d err=%b cyc=%0d, expected idx=%0d peak=%0d mean=%0d err=%b cyc=%0d", i, obs_q[i].idx, obs_q[i].peak, obs_q[i].mean, obs_q[i].err, obs_q[i].cyc, exp_q[i].idx, exp_q[i].peak, exp_q[i].mean, exp_q[i].err, exp_q[i].cyc); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_random;
    logic [DW-1:0] b[$];
    int len;
    int sel;
    for (int f = 0; f < 12; f++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0: len = BINS;
        1: len = BINS - 1;
        2: len = BINS + $urandom_range(1, 40);
        3: len = 1;
        default: len = $urandom_range(2, BINS + 60);
      endcase
      b.delete();
      for (int k = 0; k < len; k++)
        b.push_back((f % 2 == 0) ? DW'($urandom_range(0, 7)) : DW'($urandom));
      send_frame(b);
      idle($urandom_range(0, 2));
    end
    idle(3);
    vectors++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL random_count: got %0d results, expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL random[%0d]: idx=%0d peak=%0d mean=%0d err=%b cyc=%0d, expected idx=%0d peak=%0d mean=%0d err=%b cyc=%0d", i, obs_q[i].idx, obs_q[i].peak, obs_q[i].mean, obs_q[i].err, obs_q[i].cyc, exp_q[i].idx, exp_q[i].peak, exp_q[i].mean, exp_q[i].err, exp_q[i].cyc); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid_frame;
    for (int k = 0; k < 100; k++) step(DW'($urandom_range(1000, 9000)), k == 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    bus.mag_i = '0; bus.sob_i = 1'b0; bus.eob_i = 1'b0;
    in_frame = 0;
    cur.delete();
    #1;
    vectors++; if (bus.valid_o !== 1'b0 || bus.frame_err_o !== 1'b0) begin errors++; $display("FAIL midrst_flags: valid=%b err=%b, expected 0 0", bus.valid_o, bus.frame_err_o); end
    vectors++; if (bus.peak_idx_o !== '0 || bus.peak_mag_o !== '0) begin errors++; $display("FAIL midrst_result: idx=%0d peak=%0d, expected 0 0", bus.peak_idx_o, bus.peak_mag_o); end
`ifdef SPECTRUM_PEAK_MEAN_EN
    vectors++; if (bus.mean_o !== '0) begin errors++; $display("FAIL midrst_mean: got %0d, expected 0", bus.mean_o); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 101; k < BINS; k++) step(DW'($urandom_range(1000, 9000)), 1'b0, k == BINS - 1);
    idle(4);
    vectors++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL midrst_count: got %0d results, expected %0d", obs_q.size(), exp_q.size()); end
    vectors++; if (bus.peak_mag_o !== '0) begin errors++; $display("FAIL midrst_after: peak=%0d, expected 0", bus.peak_mag_o); end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_tie_back_to_back();
    test_short_long();
    test_restart_orphan();
    test_random();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/spectrum_peak_finder.md
# spectrum_peak_finder

Per-frame peak detector for the magnitude stream produced by the 18-bit CORDIC vectoring stage in the frequency machine. The block consumes `r`/`sob`/`eob` one bin per clock and reports, once per frame, the index and magnitude of the strongest bin. Optionally it also reports the mean magnitude of the frame. A frame-length check flags malformed frames.

## Interface
- `DW`, 18: magnitude width; matches the vectoring output.
- `BINS`, 512: expected bins per frame; must be a power of two ≥ 2.
- `IW`, `$clog2(BINS)`: bin index width; derived, not overridden.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `mag_i`  in  DW  magnitude, unsigned.
- `sob_i`  in  1  start of frame; first bin of the frame is on this cycle.
- `eob_i`  in  1  end of frame; last bin of the frame is on this cycle.
- `peak_idx_o`  out  IW  bin index of the maximum.
- `peak_mag_o`  out  DW  maximum magnitude.
- `mean_o`  out  DW  mean magnitude. Present only with `SPECTRUM_PEAK_MEAN_EN`.
- `frame_err_o`  out  1  length error for the reported frame.
- `valid_o`  out  1  one-cycle pulse; result outputs updated this cycle.

## Operation
- There is one bin per clock between `sob_i` and `eob_i` inclusive. Cycles outside a frame are ignored. There is no backpressure.
- The FSM has two states: IDLE and RUN. Reset state is IDLE.
  - IDLE → RUN on `sob_i` without `eob_i`.
  - IDLE stays IDLE on `sob_i` with `eob_i`. This is a single-bin frame and is reported immediately.
  - RUN → IDLE on `eob_i`.
  - RUN on `sob_i` without `eob_i`: the partial frame is discarded without any report, and the block restarts at bin 0 and stays in RUN.
- Bin counter `cnt`:
  - Loaded to 1 on `sob_i`.
  - Incremented per bin in RUN.
  - Saturates at `BINS`. The overflow sets the internal `over` flag.
- Maximum tracking:
  - On `sob_i`: `max_mag=mag_i`, `max_idx=0`.
  - Otherwise the maximum updates only if `mag_i > max_mag` (strict). On ties the lowest index wins.
  - Bins beyond `BINS` are not compared, and neither are bins seen while `over` is set.
- Frame check: `frame_err = over | (bins_in_frame != BINS)`, evaluated at `eob_i`.
- `eob_i` while in IDLE without `sob_i` is an orphan. It is ignored, with no `valid_o`.
- Arithmetic:
  - Magnitudes are unsigned with no rounding on comparisons.
  - The accumulator is `DW+IW` bits wide, unsigned, and cannot overflow for ≤ `BINS` bins.
- Reset mid-frame: all state is cleared and the FSM returns to IDLE, so a following `eob_i` is an orphan.

## Timing
- Result latency: outputs are registered and `valid_o` asserts on the cycle after the `eob_i` cycle. The `eob_i` bin itself takes part in the maximum, the mean and the count.
- Outputs hold until the next `valid_o`.
- Frames may be back-to-back: `sob_i` may arrive on the cycle right after `eob_i`, the same cycle `valid_o` is high. No bins are lost.
- Reset values: `valid_o=0`, `peak_idx_o=0`, `peak_mag_o=0`, `mean_o=0`, `frame_err_o=0`.
- Throughput: one bin per clock, sustained.

## Configuration
- `SPECTRUM_PEAK_MEAN_EN` defined:
  - Adds the accumulator and the `mean_o` port.
  - The accumulator is cleared and loaded with `mag_i` on `sob_i`, and adds each counted bin after that.
  - `mean_o = acc >> IW`, truncated. It is registered alongside the other results.
  - For an erroneous frame the mean is still `acc >> IW`.
- `SPECTRUM_PEAK_MEAN_EN` undefined: no accumulator and no `mean_o` port. All other behaviour and timing are identical.

## Test plan
- **Nominal frame:** `BINS=512`, ramp `mag=k` for k=0..511, `eob` on bin 511.
  - Result: `valid_o` one cycle later with `peak_idx=511`, `peak_mag=511`, `err=0`, `mean=255`.
- **Tie and back-to-back:**
  - Frame 1: all zeros except `mag=1000` at bins 7 and 300. Expect `idx=7`, `peak=1000`.
  - Frame 2: `sob` on the cycle after `eob`, with the peak at bin 0 (`mag=5`, rest 0). Expect two `valid_o` pulses and frame 2 reporting `idx=0`, `peak=5`.
- **Short frame:** `eob` at bin 99, peak 70000 at bin 50.
  - Result: `idx=50`, `peak=70000`, `err=1`.
- **Long frame:** 600 bins with the peak at bin 550.
  - Result: the peak comes from bins 0..511 only, and `err=1`.
- **Restart and orphan:** `sob` at bin 200 of a running frame, then a full 512-bin frame.
  - Result: exactly one `valid_o`, for the new frame. A later lone `eob` produces no `valid_o`.
- **Reset mid-frame:** pulse `rst_ni` low at bin 100.
  - Result: all outputs are 0 and the trailing `eob` is ignored.
